// File: rtl/pwm_ramp_ctrl.sv
// Duty-cycle ramp controller for an 11-bit PWM: steps duty toward a commanded target once per 2048-clock period.
// Optional PWM_RAMP_CTRL_HARD_STOP_EN: estop clears duty immediately instead of ramping it down at period boundaries.
module pwm_ramp_ctrl #(
  parameter logic [10:0] STEP = 11'd16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_vld,
  input  logic [10:0] cmd_duty,
  output logic        cmd_rdy,
  input  logic        estop,
  output logic [10:0] duty,
  output logic        period_end,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, RAMP = 2'd1, STOP = 2'd2} state_t;

  state_t      state, state_d;
  logic [10:0] cnt, target, target_d, duty_d;

  // 12-bit arithmetic so a step never wraps past 0 or 2047; the result clamps at t.
  function automatic logic [10:0] ramp_step(input logic [10:0] d, input logic [10:0] t);
    logic [11:0] up, dn;
    up = {1'b0, d} + {1'b0, STEP};
    dn = {1'b0, d} - {1'b0, STEP};
    ramp_step = d;
    if (d < t)      ramp_step = (up > {1'b0, t}) ? t : up[10:0];
    else if (d > t) ramp_step = (dn[11] || dn[10:0] < t) ? t : dn[10:0];
  endfunction

  assign period_end = (cnt == 11'h7FF);
  assign cmd_rdy    = (state != STOP) && !estop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      state  <= IDLE;
      target <= '0;
      duty   <= '0;
      busy   <= 1'b0;
    end else begin
      cnt    <= cnt + 11'd1;
      state  <= state_d;
      target <= target_d;
      duty   <= duty_d;
      busy   <= (duty_d != target_d);
    end
  end

  always_comb begin
    state_d  = state;
    target_d = target;
    duty_d   = duty;
    case (state)
      STOP: begin
        target_d = '0;
`ifdef PWM_RAMP_CTRL_HARD_STOP_EN
        duty_d = '0;
`else
        if (period_end) duty_d = ramp_step(duty, 11'd0);
`endif
        if (!estop && duty == 11'd0) state_d = IDLE;
      end
      default: begin
        if (estop) begin
          // Command offered in the estop cycle is never accepted (cmd_rdy is low).
          state_d  = STOP;
          target_d = '0;
`ifdef PWM_RAMP_CTRL_HARD_STOP_EN
          duty_d = '0;
`else
          if (period_end) duty_d = ramp_step(duty, 11'd0);
`endif
        end else begin
          // Boundary step uses the pre-edge target, so a same-edge command waits a period.
          if (period_end) duty_d = ramp_step(duty, target);
          if (cmd_vld && cmd_rdy) target_d = cmd_duty;
          state_d = (duty_d != target_d) ? RAMP : IDLE;
        end
      end
    endcase
  end

endmodule
